// File: rtl/latch_mon_pkg.sv
// Shared types for the latch output monitor: filter FSM states and the
// stability-counter sizing helper.
package latch_mon_pkg;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_TO_HIGH = 2'd1,
        ST_HIGH    = 2'd2,
        ST_TO_LOW  = 2'd3
    } filt_state_e;

    // Counter must hold values 0..stable_cycles inclusive.
    function automatic int stab_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage : latch_mon_pkg

// File: rtl/bit_sync.sv
// N-flop synchronizer for a single asynchronous bit; all stages reset to 0.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[N-2:0], d};
        end
    end

    assign q = stage_reg[N-1];

endmodule : bit_sync

// File: rtl/latch_out_monitor.sv
// Synchronizes and deglitches a latch Q output, produces rise/fall pulses,
// a saturating edge count and a one-entry valid/ready event slot.
module latch_out_monitor
    import latch_mon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             clr_cnt,
    output logic             filt_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             evt_valid,
    output logic             evt_rising,
    input  logic             evt_ready,
    output logic             overrun
);

    localparam int                STAB_W    = stab_width(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam bit                DIRECT    = (STABLE_CYCLES == 1);

    logic s;

    bit_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .q     (s)
    );

    filt_state_e       state_reg, state_next;
    logic [STAB_W-1:0] stab_reg, stab_next;
    logic [STAB_W-1:0] stab_inc;
    logic              filt_d_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              evt_valid_reg;
    logic              evt_rising_reg;
    logic              overrun_reg;
    logic              filt_level;
    logic              edge_pulse;
    logic              xfer;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_LOW;
            stab_reg  <= '0;
        end else begin
            state_reg <= state_next;
            stab_reg  <= stab_next;
        end
    end

    assign stab_inc = stab_reg + STAB_ONE;

    // Next-state logic: a candidate level must persist STABLE_CYCLES samples.
    always_comb begin
        state_next = state_reg;
        stab_next  = stab_reg;
        case (state_reg)
            ST_LOW: begin
                if (s) begin
                    if (DIRECT) begin
                        state_next = ST_HIGH;
                        stab_next  = '0;
                    end else begin
                        state_next = ST_TO_HIGH;
                        stab_next  = STAB_ONE;
                    end
                end
            end
            ST_TO_HIGH: begin
                if (!s) begin
                    state_next = ST_LOW;
                    stab_next  = '0;
                end else if (stab_inc == STAB_LAST) begin
                    state_next = ST_HIGH;
                    stab_next  = '0;
                end else begin
                    stab_next  = stab_inc;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (DIRECT) begin
                        state_next = ST_LOW;
                        stab_next  = '0;
                    end else begin
                        state_next = ST_TO_LOW;
                        stab_next  = STAB_ONE;
                    end
                end
            end
            ST_TO_LOW: begin
                if (s) begin
                    state_next = ST_HIGH;
                    stab_next  = '0;
                end else if (stab_inc == STAB_LAST) begin
                    state_next = ST_LOW;
                    stab_next  = '0;
                end else begin
                    stab_next  = stab_inc;
                end
            end
            default: begin
                state_next = ST_LOW;
                stab_next  = '0;
            end
        endcase
    end

    // Output logic: the accepted level holds through the TO_LOW candidate window.
    always_comb begin
        filt_level = 1'b0;
        case (state_reg)
            ST_HIGH, ST_TO_LOW: filt_level = 1'b1;
            default:            filt_level = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_d_reg <= 1'b0;
        end else begin
            filt_d_reg <= filt_level;
        end
    end

    assign filt_q     = filt_level;
    assign rise       = filt_level & ~filt_d_reg;
    assign fall       = ~filt_level & filt_d_reg;
    assign edge_pulse = rise | fall;
    assign xfer       = evt_valid_reg & evt_ready;

    // Saturating edge counter; clear takes priority over a coincident edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (edge_pulse && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Event slot: a transfer in the same cycle frees room for the new edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_valid_reg  <= 1'b0;
            evt_rising_reg <= 1'b0;
        end else if (edge_pulse && (!evt_valid_reg || evt_ready)) begin
            evt_valid_reg  <= 1'b1;
            evt_rising_reg <= rise;
        end else if (xfer) begin
            evt_valid_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_reg <= 1'b0;
        end else if (clr_cnt) begin
            overrun_reg <= 1'b0;
        end else if (edge_pulse && evt_valid_reg && !evt_ready) begin
            overrun_reg <= 1'b1;
        end
    end

    assign edge_cnt   = cnt_reg;
    assign evt_valid  = evt_valid_reg;
    assign evt_rising = evt_rising_reg;
    assign overrun    = overrun_reg;

endmodule : latch_out_monitor
